serial_bit_feeder: RTL and testbench
====================================

// Module: serial_bit_feeder
// PURPOSE
//   Upstream stage for the Mealy sequence-detector FSM. Accepts a parallel
//   WIDTH-bit word over a valid/ready handshake and presents it MSB-first on
//   a 1-bit serial line, one bit per clock. Drives the FSM's reset so that
//   the FSM runs only while real bits stream, with no testbench sequencing.
// PARAMETERS
//   WIDTH        32  bits per word, >= 2
//   CNT_W        6   width of bit_idx, >= clog2(WIDTH)
//   RST_BETWEEN  0   1: pulse fsm_rst between words; 0: FSM state carries across words
// PORTS
//   Clk_s      in   1       clock, all logic on rising edge
//   Rst_s      in   1       synchronous, active-high reset
//   din        in   WIDTH   parallel word, sampled only on accept
//   din_valid  in   1       producer has a word on din
//   din_ready  out  1       feeder can accept din this cycle
//   x          out  1       serial bit to FSM input
//   x_valid    out  1       x carries a real bit this cycle
//   fsm_rst    out  1       reset to downstream FSM, active-high
//   bit_idx    out  CNT_W   index within din of the bit currently on x
//   done       out  1       high during the cycle x carries bit 0
// BEHAVIOUR
//   - States: IDLE, SHIFT. Registers: state, shreg[WIDTH], cnt[CNT_W], started.
//   - Reset (Rst_s=1 at an edge): state=IDLE, shreg=0, cnt=0, started=0.
//     While Rst_s=1, din_ready=0, so no accept can happen.
//     Outputs after reset: x=0, x_valid=0, done=0, bit_idx=0, fsm_rst=1.
//   - Accept = din_valid && din_ready at an edge.
//     On accept: shreg<=din, cnt<=WIDTH-1, state<=SHIFT, started<=1.
//   - din_ready rules:
//       RST_BETWEEN=0: din_ready = !Rst_s && (IDLE || (SHIFT && cnt==0))
//       RST_BETWEEN=1: din_ready = !Rst_s && IDLE
//   - SHIFT: x=shreg[WIDTH-1], x_valid=1, bit_idx=cnt.
//     Each edge: shreg<=shreg<<1, cnt<=cnt-1.
//   - Timing: first bit on x the cycle after accept (latency 1).
//     Cycle k after accept (k=0..WIDTH-1): x=din[WIDTH-1-k].
//   - cnt==0 in SHIFT: done=1. Next edge goes to IDLE, or reloads on accept
//     (back-to-back, no bubble when RST_BETWEEN=0).
//   - IDLE: x=0, x_valid=0, done=0, bit_idx=0.
//   - fsm_rst (combinational from state/started):
//       1 while Rst_s=1 or in IDLE before the first word; 0 in SHIFT.
//       RST_BETWEEN=1: 1 in every IDLE cycle, so at least one FSM-reset
//         cycle separates words.
//       RST_BETWEEN=0: 0 in IDLE once started=1, so FSM state is preserved.
//   - din_valid while din_ready=0 is ignored; din is not sampled, and the
//     producer must hold the word until accepted.
//   - Reset mid-word: the word is discarded, done never fires, and the
//     outputs above hold from the next cycle.
//   - No other inputs change state. cnt never wraps: reload happens only at cnt==0.
// TESTING
//   1. Reset 1 cycle, din=32'h0B2F8455, din_valid 1 cycle
//      -> x = 0000_1011_0010_1111_1000_0100_0101_0101 over 32 cycles;
//         x_valid=1 and fsm_rst=0 throughout; done only on the 32nd bit.
//   2. RST_BETWEEN=0, din_valid held high, din=FFFFFFFF then 00000000
//      -> 64 contiguous valid bits (32 ones then 32 zeros), no x_valid gap,
//         fsm_rst=0, din_ready high only on the two cnt==0 cycles.
//   3. RST_BETWEEN=1, same stimulus as 2
//      -> exactly one cycle with x_valid=0, fsm_rst=1, din_ready=1 between
//         the words; 65 cycles total from first bit to last bit.
//   4. Rst_s=1 while bit_idx=21
//      -> next cycle x_valid=0, fsm_rst=1, din_ready=0, no done pulse;
//         after release din_ready=1 and a new word streams normally.
//   5. din_valid pulsed with din=AAAAAAAA while bit_idx=10 of a 0x0 word
//      -> din_ready=0, pulse ignored; remaining bits stay 0.
//   6. WIDTH=4, CNT_W=2, din=4'b1010
//      -> x=1,0,1,0 with bit_idx=3,2,1,0; done with bit_idx=0.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end for the sequence-detector FSM: accepts a word on a
// valid/ready handshake, streams it MSB-first one bit per clock, and owns the FSM reset.
module serial_bit_feeder #(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 6,
  parameter bit RST_BETWEEN = 1'b0
) (
  input  logic             Clk_s,
  input  logic             Rst_s,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             fsm_rst,
  output logic [CNT_W-1:0] bit_idx,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             started;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state == SHIFT) && (cnt == '0);

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    din_ready = 1'b0;
    if (!Rst_s) begin
      if (RST_BETWEEN) din_ready = (state == IDLE);
      else             din_ready = (state == IDLE) || last_bit;
    end
  end

  assign accept = din_valid && din_ready;

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clk_s) begin
    if (Rst_s) begin
      // NOTE: the shift register is a plain register bank, so it is cleared by
      // reset like the rest of the state rather than being left uninitialised.
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      started <= 1'b0;
    end else if (accept) begin
      state   <= SHIFT;
      shreg   <= din;
      cnt     <= CNT_W'(WIDTH - 1);
      started <= 1'b1;
    end else if (state == SHIFT) begin
      shreg <= shreg << 1;
      // Leave cnt parked at zero on the way out so it never wraps.
      if (last_bit) state <= IDLE;
      else          cnt   <= cnt - 1'b1;
    end
  end

  assign x       = (state == SHIFT) && shreg[WIDTH-1];
  assign x_valid = (state == SHIFT);
  assign bit_idx = (state == SHIFT) ? cnt : '0;
  assign done    = last_bit;

  // Before the first word the FSM is always held in reset; afterwards the idle
  // gap either resets it again or lets its state carry into the next word.
  assign fsm_rst = Rst_s || ((state == IDLE) && (RST_BETWEEN || !started));

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: three instances (32-bit carry, 32-bit reset-between,
// 4-bit carry) share one stimulus and are compared every cycle with a word/position model.
module tb_serial_bit_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;

  logic        rdy  [3];
  logic        xo   [3];
  logic        xv   [3];
  logic        frst [3];
  logic        dn   [3];
  logic [5:0]  idx0, idx1;
  logic [1:0]  idx2;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(32), .CNT_W(6), .RST_BETWEEN(1'b0)) dut0 (
    .Clk_s(clk), .Rst_s(rst), .din(din), .din_valid(din_valid), .din_ready(rdy[0]),
    .x(xo[0]), .x_valid(xv[0]), .fsm_rst(frst[0]), .bit_idx(idx0), .done(dn[0]));

  serial_bit_feeder #(.WIDTH(32), .CNT_W(6), .RST_BETWEEN(1'b1)) dut1 (
    .Clk_s(clk), .Rst_s(rst), .din(din), .din_valid(din_valid), .din_ready(rdy[1]),
    .x(xo[1]), .x_valid(xv[1]), .fsm_rst(frst[1]), .bit_idx(idx1), .done(dn[1]));

  serial_bit_feeder #(.WIDTH(4), .CNT_W(2), .RST_BETWEEN(1'b0)) dut2 (
    .Clk_s(clk), .Rst_s(rst), .din(din[3:0]), .din_valid(din_valid), .din_ready(rdy[2]),
    .x(xo[2]), .x_valid(xv[2]), .fsm_rst(frst[2]), .bit_idx(idx2), .done(dn[2]));

  // Reference model: the word being streamed and how many cycles since it was accepted.
  int          w_of  [3] = '{32, 32, 4};
  bit          rb_of [3] = '{1'b0, 1'b1, 1'b0};
  int          pos   [3];
  logic [31:0] word  [3];
  bit          started [3];

  // Output snapshots taken on the falling edge of the last cycle() call.
  logic s_x [3], s_xv [3], s_rdy [3], s_fr [3], s_dn [3];
  int   s_idx [3];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, i, act, exp, $time);
    end
  endtask

  function automatic int get_idx(input int i);
    case (i)
      0:       return int'(idx0);
      1:       return int'(idx1);
      default: return int'(idx2);
    endcase
  endfunction

  function automatic bit model_ready(input int i);
    return !rst && (pos[i] < 0 || (!rb_of[i] && pos[i] == w_of[i] - 1));
  endfunction

  // One clock: compare on the falling edge, advance the model at the rising edge,
  // then return 1 time unit later so callers may change inputs safely.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      logic e_x, e_xv, e_dn, e_fr, e_rdy;
      int   e_idx;
      e_rdy = model_ready(i);
      if (pos[i] >= 0) begin
        e_x   = word[i][w_of[i] - 1 - pos[i]];
        e_xv  = 1'b1;
        e_idx = w_of[i] - 1 - pos[i];
        e_dn  = (pos[i] == w_of[i] - 1);
        e_fr  = rst;
      end else begin
        e_x   = 1'b0;
        e_xv  = 1'b0;
        e_idx = 0;
        e_dn  = 1'b0;
        e_fr  = rst || rb_of[i] || !started[i];
      end
      s_x[i]   = xo[i];
      s_xv[i]  = xv[i];
      s_rdy[i] = rdy[i];
      s_fr[i]  = frst[i];
      s_dn[i]  = dn[i];
      s_idx[i] = get_idx(i);
      check("model_x",       i, s_x[i],   e_x);
      check("model_x_valid", i, s_xv[i],  e_xv);
      check("model_ready",   i, s_rdy[i], e_rdy);
      check("model_fsm_rst", i, s_fr[i],  e_fr);
      check("model_done",    i, s_dn[i],  e_dn);
      check("model_bit_idx", i, s_idx[i], e_idx);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        pos[i]     = -1;
        started[i] = 1'b0;
      end else if (din_valid && model_ready(i)) begin
        pos[i]     = 0;
        word[i]    = din;
        started[i] = 1'b1;
      end else if (pos[i] >= 0) begin
        pos[i] = (pos[i] == w_of[i] - 1) ? -1 : pos[i] + 1;
      end
    end
    #1;
  endtask

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp_bits;  // serial stream, first bit on the left
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs [4];
    logic [31:0] e;
    logic [3:0]  e6;
    int          rdy_cnt, gap_cnt, xv1_cnt, last_c, done_cnt, ones;

    vecs[0] = '{32'h0B2F8455, 32'b0000_1011_0010_1111_1000_0100_0101_0101};
    vecs[1] = '{32'hFFFF0000, 32'b1111_1111_1111_1111_0000_0000_0000_0000};
    vecs[2] = '{32'h80000001, 32'b1000_0000_0000_0000_0000_0000_0000_0001};
    vecs[3] = '{32'h5A5AC3C3, 32'b0101_1010_0101_1010_1100_0011_1100_0011};

    for (int i = 0; i < 3; i++) begin
      pos[i] = -1; word[i] = '0; started[i] = 1'b0;
    end
    rst = 1'b1; din = '0; din_valid = 1'b0;

    // Reset state
    cycle();
    cycle();
    for (int i = 0; i < 3; i++) begin
      check("rst_ready",   i, s_rdy[i], 1'b0);
      check("rst_fsm_rst", i, s_fr[i],  1'b1);
      check("rst_x_valid", i, s_xv[i],  1'b0);
      check("rst_bit_idx", i, s_idx[i], 0);
    end
    rst = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      check("post_rst_ready",   i, s_rdy[i], 1'b1);
      check("post_rst_fsm_rst", i, s_fr[i],  1'b1);
    end

    // Table-driven single words on the 32-bit carry instance
    for (int r = 0; r < 4; r++) begin
      din = vecs[r].din; din_valid = 1'b1;
      cycle();
      din_valid = 1'b0;
      e = vecs[r].exp_bits;
      for (int k = 0; k < 32; k++) begin
        cycle();
        check("tbl_x",       0, s_x[0],   e[31-k]);
        check("tbl_x_valid", 0, s_xv[0],  1'b1);
        check("tbl_fsm_rst", 0, s_fr[0],  1'b0);
        check("tbl_done",    0, s_dn[0],  k == 31);
        check("tbl_bit_idx", 0, s_idx[0], 31 - k);
      end
    end
    cycle();

    // Back-to-back words with din_valid held high
    din = 32'hFFFFFFFF; din_valid = 1'b1;
    cycle();
    din = 32'h00000000;
    rdy_cnt = 0; gap_cnt = 0; xv1_cnt = 0; last_c = -1;
    for (int c = 0; c < 66; c++) begin
      cycle();
      if (c == 32) din_valid = 1'b0;
      if (c < 64) begin
        check("b2b_x",       0, s_x[0],  c < 32);
        check("b2b_x_valid", 0, s_xv[0], 1'b1);
        check("b2b_fsm_rst", 0, s_fr[0], 1'b0);
        if (s_rdy[0]) rdy_cnt++;
      end
      if (c < 65) begin
        if (s_xv[1]) begin xv1_cnt++; last_c = c; end
        if (!s_xv[1] && s_fr[1] && s_rdy[1]) gap_cnt++;
      end
    end
    check("b2b_ready_count",     0, rdy_cnt, 2);
    check("rb_gap_count",        1, gap_cnt, 1);
    check("rb_valid_bits",       1, xv1_cnt, 64);
    check("rb_first_to_last",    1, last_c + 1, 65);

    // Reset in the middle of a word
    din = 32'h12345678; din_valid = 1'b1;
    cycle();
    din_valid = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    rst = 1'b1;
    cycle();
    check("midrst_bit_idx", 0, s_idx[0], 21);
    check("midrst_ready",   0, s_rdy[0], 1'b0);
    cycle();
    check("midrst_x_valid", 0, s_xv[0], 1'b0);
    check("midrst_fsm_rst", 0, s_fr[0], 1'b1);
    check("midrst_ready2",  0, s_rdy[0], 1'b0);
    check("midrst_done",    0, s_dn[0], 1'b0);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      cycle();
      if (k == 0) check("midrst_release_ready", 0, s_rdy[0], 1'b1);
      if (s_dn[0]) done_cnt++;
    end
    check("midrst_no_done", 0, done_cnt, 0);
    din = 32'hC3A55A3C; din_valid = 1'b1;
    cycle();
    din_valid = 1'b0;
    e = 32'hC3A55A3C;
    done_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      cycle();
      check("after_rst_x", 0, s_x[0], e[31-k]);
      if (s_dn[0]) done_cnt++;
    end
    check("after_rst_done_count", 0, done_cnt, 1);

    // Ignored valid pulse while busy
    din = 32'h00000000; din_valid = 1'b1;
    cycle();
    din_valid = 1'b0;
    ones = 0;
    for (int k = 0; k < 32; k++) begin
      if (k == 21) begin din = 32'hAAAAAAAA; din_valid = 1'b1; end
      cycle();
      if (k == 21) begin
        check("busy_bit_idx", 0, s_idx[0], 10);
        check("busy_ready",   0, s_rdy[0], 1'b0);
        din_valid = 1'b0; din = 32'h0;
      end
      if (k > 21 && s_x[0]) ones++;
    end
    check("busy_ignored_ones", 0, ones, 0);
    cycle();

    // Narrow instance: 4'b1010
    din = 32'h0000000A; din_valid = 1'b1;
    cycle();
    din_valid = 1'b0;
    e6 = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("w4_x",       2, s_x[2],   e6[3-k]);
      check("w4_x_valid", 2, s_xv[2],  1'b1);
      check("w4_bit_idx", 2, s_idx[2], 3 - k);
      check("w4_done",    2, s_dn[2],  k == 3);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      din_valid = ($urandom_range(0, 3) != 0);
      din       = $urandom;
      cycle();
    end
    rst = 1'b0; din_valid = 1'b0;
    for (int n = 0; n < 40; n++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
